// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply with accumulate modes,
// radix-2 restoring divide, flushable, with busy for the hazard unit.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] multdivout
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX} state_t;

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] MOP_SET = 2'd0;
  localparam logic [1:0] MOP_ADD = 2'd1;
  localparam logic [1:0] MOP_SUB = 2'd2;

  state_t state, state_nxt;

  logic [5:0] opcode, funct;
  logic       is_special, is_special2;
  logic       dec_mult, dec_multu, dec_div, dec_divu, dec_mfhi, dec_mthi, dec_mtlo;
  logic       dec_madd, dec_maddu, dec_msub, dec_msubu;
  logic       is_mul, is_div, mul_signed, accept;
  logic [1:0] mop_dec;
  logic       unused_instr_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign is_special  = (opcode == 6'h00);
  assign is_special2 = (opcode == 6'h1C);
  assign dec_mult    = is_special && (funct == 6'h18);
  assign dec_multu   = is_special && (funct == 6'h19);
  assign dec_div     = is_special && (funct == 6'h1A);
  assign dec_divu    = is_special && (funct == 6'h1B);
  assign dec_mfhi    = is_special && (funct == 6'h10);
  assign dec_mthi    = is_special && (funct == 6'h11);
  assign dec_mtlo    = is_special && (funct == 6'h13);
  assign dec_madd    = is_special2 && (funct == 6'h00);
  assign dec_maddu   = is_special2 && (funct == 6'h01);
  assign dec_msub    = is_special2 && (funct == 6'h04);
  assign dec_msubu   = is_special2 && (funct == 6'h05);

  assign is_mul     = dec_mult | dec_multu | dec_madd | dec_maddu | dec_msub | dec_msubu;
  assign is_div     = dec_div | dec_divu;
  assign mul_signed = dec_mult | dec_madd | dec_msub;
  assign mop_dec    = (dec_madd | dec_maddu) ? MOP_ADD :
                      (dec_msub | dec_msubu) ? MOP_SUB : MOP_SET;
  assign accept     = instr_valid && !flush && (state == S_IDLE);

  // Operands extended to 2*WIDTH so one truncated product serves signed and unsigned.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  assign a_ext = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = a_ext * b_ext;

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (dec_div && a[WIDTH-1]) ? -a : a;
  assign abs_b = (dec_div && b[WIDTH-1]) ? -b : b;

  logic [2*WIDTH-1:0] pend, acc_nxt;
  logic [1:0]         mop;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   quot, dvs, rem;
  logic               q_neg, r_neg, dz, start_q;

  always_comb begin
    acc_nxt = pend;
    case (mop)
      MOP_ADD: acc_nxt = {hi, lo} + pend;
      MOP_SUB: acc_nxt = {hi, lo} - pend;
      default: acc_nxt = pend;
    endcase
  end

  // One restoring step: shift the next dividend bit in, keep the trial difference if non-negative.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             take;
  assign rem_sh = {rem, quot[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
  assign take   = !diff[WIDTH+1];

  logic [WIDTH-1:0] quot_f, rem_f;
  assign quot_f = q_neg ? -quot : quot;
  assign rem_f  = r_neg ? -rem : rem;

  assign unused_instr_bits = ^{instr[25:6], diff[WIDTH]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)      state_nxt = S_MUL;
        else if (accept && is_div) state_nxt = S_DIV_ITER;
      end
      S_MUL:      if (flush || cnt == CNT_ONE) state_nxt = S_IDLE;
      S_DIV_ITER: begin
        if (flush)                state_nxt = S_IDLE;
        else if (cnt == CNT_ONE)  state_nxt = S_DIV_FIX;
      end
      S_DIV_FIX:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    start      = start_q;
    multdivout = dec_mfhi ? hi : lo;
  end

  // Datapath: flush in any busy state suppresses every HI/LO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0; lo <= '0; pend <= '0; mop <= MOP_SET; cnt <= '0;
      quot <= '0; dvs <= '0; rem <= '0;
      q_neg <= 1'b0; r_neg <= 1'b0; dz <= 1'b0; start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              pend <= prod; mop <= mop_dec; cnt <= MUL_INIT; start_q <= 1'b1;
            end else if (is_div) begin
              quot <= abs_a; dvs <= abs_b; rem <= '0;
              q_neg <= dec_div && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg <= dec_div && a[WIDTH-1];
              dz <= (b == '0);
              cnt <= DIV_INIT; start_q <= 1'b1;
            end else if (dec_mthi) begin
              hi <= a;
            end else if (dec_mtlo) begin
              lo <= a;
            end
          end
        end
        S_MUL: begin
          if (!flush) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) {hi, lo} <= acc_nxt;
          end
        end
        S_DIV_ITER: begin
          if (!flush) begin
            rem  <= take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], take};
            cnt  <= cnt - CNT_ONE;
          end
        end
        S_DIV_FIX: begin
          if (!flush) begin
            lo <= dz ? '1 : quot_f;
            hi <= rem_f;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, accumulate, flush, reset and issue blocking.
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MADDU = 32'h7000_0001;
  localparam logic [31:0] I_MSUB  = 32'h7000_0004;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [W-1:0] a, b;
  logic         flush;
  logic         start, busy;
  logic [W-1:0] hi, lo, multdivout;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(5)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .a(a), .b(b), .flush(flush), .start(start), .busy(busy),
    .hi(hi), .lo(lo), .multdivout(multdivout)
  );

  always #5 clk = ~clk;

  // Issue one instruction for one cycle; returns at the negedge after the issue edge.
  task automatic issue(input logic [31:0] ins, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    instr_valid = 1'b1; instr = ins; a = aa; b = bb;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Counts busy cycles and start pulses until busy drops, bounded at 200 cycles.
  task automatic wait_done(output int n, output int st);
    n = 0; st = 0;
    while (busy && n < 200) begin
      n++;
      if (start) st++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_valid = 1'b0; instr = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
    n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int n, st;
    issue(I_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(n, st);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", n); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL mult_start: got %0d want 1", st); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    issue(I_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(n, st);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL multu_busy: got %0d want 5", n); end
    n_cmp++; if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_div();
    int n, st;
    issue(I_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, st);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL div_busy: got %0d want 33", n); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL div_start: got %0d want 1", st); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    issue(I_DIVU, 32'd7, 32'd2);
    wait_done(n, st);
    n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 3", lo); end
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 1", hi); end
    instr = I_MFHI; #1;
    n_cmp++; if (multdivout !== 32'd1) begin n_err++; $display("FAIL mfhi_out: got %h want 1", multdivout); end
    instr = I_MFLO; #1;
    n_cmp++; if (multdivout !== 32'd3) begin n_err++; $display("FAIL mflo_out: got %h want 3", multdivout); end
  endtask

  task automatic test_div_edge();
    int n, st;
    issue(I_DIV, 32'd5, 32'd0);
    wait_done(n, st);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL divz_busy: got %0d want 33", n); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'd5) begin n_err++; $display("FAIL divz_hi: got %h want 5", hi); end
    issue(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, st);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divov_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL divov_hi: got %h want 0", hi); end
  endtask

  task automatic test_accum();
    int n, st;
    issue(I_MTLO, 32'hFFFF_FFFF, 32'd0);
    wait_done(n, st);
    n_cmp++; if (n !== 0 || st !== 0) begin n_err++; $display("FAIL mt_busy: got busy %0d start %0d want 0 0", n, st); end
    issue(I_MTHI, 32'd0, 32'd0);
    issue(I_MADDU, 32'd1, 32'd1);
    wait_done(n, st);
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL maddu_hi: got %h want 1", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL maddu_lo: got %h want 0", lo); end
    issue(I_MTHI, 32'd0, 32'd0);
    issue(I_MTLO, 32'd0, 32'd0);
    issue(I_MSUB, 32'd1, 32'd1);
    wait_done(n, st);
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msub_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msub_lo: got %h want ffffffff", lo); end
  endtask

  task automatic test_flush_reset();
    issue(I_MTHI, 32'h11, 32'd0);
    issue(I_MTLO, 32'h22, 32'd0);
    issue(I_DIV, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h11) begin n_err++; $display("FAIL flush_hi: got %h want 11", hi); end
    n_cmp++; if (lo !== 32'h22) begin n_err++; $display("FAIL flush_lo: got %h want 22", lo); end
    issue(I_MULT, 32'd6, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(I_DIVU, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 3) begin instr_valid = 1'b1; instr = I_MULT; a = 32'd9; b = 32'd9; end
      else if (n == 5) begin instr_valid = 1'b1; instr = I_MTLO; a = 32'h55; end
      else instr_valid = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL ignore_busy: got %0d want 33", n); end
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL ignore_lo: got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL ignore_hi: got %h want 2", hi); end
    @(negedge clk);
    instr_valid = 1'b1; flush = 1'b1; instr = I_MULT; a = 32'd3; b = 32'd3;
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (start !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_flush: got start %b busy %b want 0 0", start, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || lo !== 32'd14) begin n_err++; $display("FAIL idle_flush_hold: got busy %b lo %h want 0 0000000e", busy, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_accum();
    test_flush_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS execute stage.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and adds the MADD/MADDU/MSUB/MSUBU accumulate modes.
- Multiply has a fixed, configurable latency. Divide is an iterative radix-2 restoring divider.
- Supports a pipeline flush that aborts an in-flight operation without touching HI/LO.
- busy feeds the hazard unit, which stalls dependent instructions.

Parameters:
WIDTH, 32, operand / HI / LO width (≥4)
MUL_LAT, 5, busy cycles for multiply-class ops (≥1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (low clears all state immediately)
instr_valid  input  1  instr is a real issued instruction this cycle
instr  input  32  instruction word; opcode [31:26], funct [5:0]
a  input  WIDTH  rs operand
b  input  WIDTH  rt operand
flush  input  1  abort in-flight op; HI/LO keep pre-op values
start  output  1  one-cycle pulse: op accepted
busy  output  1  operation in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
multdivout  output  WIDTH  hi when decoded MFHI, else lo (combinational)

Behaviour:
- Decode (opcode 0): MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- Decode (opcode 0x1C): MADD 0x00, MADDU 0x01, MSUB 0x04, MSUBU 0x05.
- Reset low: start=0, busy=0, hi=0, lo=0; FSM→IDLE; counter=0; internal operand/remainder registers cleared. Aborts any op.
- FSM states: IDLE, MUL, DIV_ITER, DIV_FIX.
- IDLE, instr_valid & multiply-class & !flush:
  - Capture the full 2·WIDTH product (signed for MULT/MADD/MSUB, unsigned for *U) into a pending register.
  - start=1 next cycle; →MUL with counter=MUL_LAT.
- MUL:
  - busy=1; counter decrements each cycle.
  - On the edge where counter reaches 1:
    - {hi,lo} ← P for MULT/MULTU.
    - {hi,lo} ← {hi,lo}+P for MADD/MADDU.
    - {hi,lo} ← {hi,lo}−P for MSUB/MSUBU.
    - All updates are modulo 2^(2·WIDTH); →IDLE.
  - busy is high exactly MUL_LAT cycles, starting the cycle after issue.
- IDLE, instr_valid & DIV/DIVU & !flush:
  - Latch |a|, |b| (signed) or raw a, b (unsigned), plus the quotient and remainder signs.
  - start pulse; →DIV_ITER with counter=WIDTH.
- DIV_ITER:
  - One restoring shift/subtract step per cycle for WIDTH cycles, then →DIV_FIX.
- DIV_FIX:
  - Apply signs. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write lo=quotient, hi=remainder; →IDLE.
  - Divide busy = WIDTH+1 cycles.
- Divide by zero (b=0, signed or unsigned): full latency, then lo=all ones, hi=a.
- Signed overflow (a=most-negative, b=−1): lo=a, hi=0.
- MTHI/MTLO: only in IDLE with instr_valid & !flush; hi/lo ← a on that edge; no start, no busy.
- While busy, every instr_valid issue (including MTHI/MTLO) is ignored; the hazard unit must stall. hi/lo hold pre-op values until the completion edge.
- flush=1 in any non-IDLE state: →IDLE next edge, busy=0, hi/lo unchanged, start=0.
- flush with a simultaneous issue in IDLE: issue ignored.
- A new issue is accepted on the cycle busy is 0 (the cycle after completion); no back-to-back issue on the completion edge.
- multdivout is combinational from hi/lo and the current instr decode; it is independent of busy.

Test Plan:
1. MULT a=0xFFFFFFFE, b=3 → busy high exactly 5 cycles, start one pulse, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
2. DIV a=0xFFFFFFF9 (−7), b=2 → busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. MFHI/MFLO select via multdivout.
3. DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. MTLO 0xFFFFFFFF, MTHI 0, then MADDU a=1, b=1 → hi=1, lo=0. MTHI 0, MTLO 0, then MSUB a=1, b=1 → hi=lo=0xFFFFFFFF.
5. Preload hi=0x11, lo=0x22; DIV issued, flush on the 3rd busy cycle → busy=0 next cycle, hi=0x11, lo=0x22. MULT issued, reset low on the 2nd busy cycle → immediately busy=0, hi=lo=0.
6. During a DIV, issue MULT and MTLO 0x55 → both ignored, DIV result intact. MULT issued with flush=1 in IDLE → no start, no busy.
